commit_unit: RTL and testbench

COMMIT_UNIT -- requirements
Module: commit_unit

---
 rtl/commit_unit.sv | 207 ++++++++++++++++++++
 tb/tb_commit_unit.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/commit_unit.sv
// commit_unit: in-order retire buffer for a FETCH_W-wide out-of-order core.
//
// Ports:
//   clk, reset_n         clock, asynchronous active-low reset
//   disp_*               dispatch group from rename (valid, dest info per lane)
//   disp_ready           buffer can take a full FETCH_W group this cycle
//   disp_rob_idx         per-lane buffer index assigned if the group is accepted
//   wb_en, wb_rob_idx    completion strobes from execute
//   flush                synchronous squash of every uncommitted entry
//   commit_*, free_*     one-cycle registered pulses for rename map / free list
//   retire_valid         one instruction retired last edge
//   rob_count            number of occupied entries
module commit_unit #(
  parameter int unsigned FETCH_W   = 2,
  parameter int unsigned ROB_DEPTH = 16,
  parameter int unsigned PHYS_REGS = 48,
  localparam int unsigned IDX_W    = $clog2(ROB_DEPTH),
  localparam int unsigned CNT_W    = IDX_W + 1,
  localparam int unsigned PTAG_W   = $clog2(PHYS_REGS)
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [FETCH_W-1:0]               disp_valid,
  input  logic [FETCH_W-1:0]               disp_rd_valid,
  input  logic [FETCH_W-1:0][4:0]          disp_arch_rd,
  input  logic [FETCH_W-1:0][PTAG_W-1:0]   disp_phys_rd,
  input  logic [FETCH_W-1:0][PTAG_W-1:0]   disp_old_phys_rd,
  output logic                             disp_ready,
  output logic [FETCH_W-1:0][IDX_W-1:0]    disp_rob_idx,
  input  logic [FETCH_W-1:0]               wb_en,
  input  logic [FETCH_W-1:0][IDX_W-1:0]    wb_rob_idx,
  input  logic                             flush,
  output logic                             commit_en,
  output logic [4:0]                       commit_arch_rd,
  output logic [PTAG_W-1:0]                commit_phys_rd,
  output logic                             free_en,
  output logic [PTAG_W-1:0]                free_phys,
  output logic                             retire_valid,
  output logic [CNT_W-1:0]                 rob_count
);

  // Entry control state
  logic [ROB_DEPTH-1:0] valid_q, valid_d;
  logic [ROB_DEPTH-1:0] done_q, done_d;
  logic [ROB_DEPTH-1:0] rd_valid_q, rd_valid_d;
  // Entry payload (no reset needed: only read when the valid bit is set)
  logic [4:0]        arch_q [ROB_DEPTH];
  logic [4:0]        arch_d [ROB_DEPTH];
  logic [PTAG_W-1:0] phys_q [ROB_DEPTH];
  logic [PTAG_W-1:0] phys_d [ROB_DEPTH];
  logic [PTAG_W-1:0] old_q  [ROB_DEPTH];
  logic [PTAG_W-1:0] old_d  [ROB_DEPTH];

  logic [IDX_W-1:0] head_q, head_d;
  logic [IDX_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic              commit_en_q, commit_en_d;
  logic [4:0]        commit_arch_q, commit_arch_d;
  logic [PTAG_W-1:0] commit_phys_q, commit_phys_d;
  logic              free_en_q, free_en_d;
  logic [PTAG_W-1:0] free_phys_q, free_phys_d;
  logic              retire_valid_q, retire_valid_d;

  logic [FETCH_W-1:0][IDX_W-1:0] lane_idx;
  logic [IDX_W-1:0]              tail_adv;
  logic [CNT_W-1:0]              n_acc;
  logic [CNT_W-1:0]              free_cnt;
  logic                          accept;
  logic                          retire;

  assign free_cnt   = CNT_W'(ROB_DEPTH) - count_q;
  assign disp_ready = (free_cnt >= CNT_W'(FETCH_W));
  assign accept     = disp_ready & ~flush;
  // valid implies rob_count > 0, so an empty buffer can never retire
  assign retire     = valid_q[head_q] & done_q[head_q] & ~flush;

  // Compact valid lanes onto consecutive indices starting at tail
  always_comb begin
    tail_adv = tail_q;
    n_acc    = '0;
    lane_idx = '0;
    for (int i = 0; i < FETCH_W; i++) begin
      lane_idx[i] = tail_adv;
      if (disp_valid[i]) begin
        tail_adv = tail_adv + IDX_W'(1);
        n_acc    = n_acc + CNT_W'(1);
      end
    end
  end

  // While in reset, present plain lane order rather than the compacted view
  always_comb begin
    disp_rob_idx = '0;
    for (int i = 0; i < FETCH_W; i++) begin
      disp_rob_idx[i] = reset_n ? lane_idx[i] : IDX_W'(i);
    end
  end

  always_comb begin
    valid_d    = valid_q;
    done_d     = done_q;
    rd_valid_d = rd_valid_q;
    arch_d     = arch_q;
    phys_d     = phys_q;
    old_d      = old_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;

    if (flush) begin
      valid_d = '0;
      done_d  = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      for (int i = 0; i < FETCH_W; i++) begin
        if (wb_en[i] && valid_q[wb_rob_idx[i]]) begin
          done_d[wb_rob_idx[i]] = 1'b1;
        end
      end
      // Clearing after writeback means a late writeback to the head cannot revive it
      if (retire) begin
        valid_d[head_q] = 1'b0;
        done_d[head_q]  = 1'b0;
        head_d          = head_q + IDX_W'(1);
      end
      // Accepted slots are always free, so they never collide with the head
      if (accept) begin
        for (int i = 0; i < FETCH_W; i++) begin
          if (disp_valid[i]) begin
            valid_d[lane_idx[i]]    = 1'b1;
            done_d[lane_idx[i]]     = 1'b0;
            rd_valid_d[lane_idx[i]] = disp_rd_valid[i] && (disp_arch_rd[i] != 5'd0);
            arch_d[lane_idx[i]]     = disp_arch_rd[i];
            phys_d[lane_idx[i]]     = disp_phys_rd[i];
            old_d[lane_idx[i]]      = disp_old_phys_rd[i];
          end
        end
        tail_d = tail_adv;
      end
      count_d = count_q + (accept ? n_acc : '0) - CNT_W'(retire);
    end
  end

  always_comb begin
    commit_en_d    = 1'b0;
    commit_arch_d  = '0;
    commit_phys_d  = '0;
    free_en_d      = 1'b0;
    free_phys_d    = '0;
    retire_valid_d = retire;
    if (retire && rd_valid_q[head_q]) begin
      commit_en_d   = 1'b1;
      commit_arch_d = arch_q[head_q];
      commit_phys_d = phys_q[head_q];
      free_en_d     = 1'b1;
      free_phys_d   = old_q[head_q];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q        <= '0;
      done_q         <= '0;
      rd_valid_q     <= '0;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      commit_en_q    <= 1'b0;
      commit_arch_q  <= '0;
      commit_phys_q  <= '0;
      free_en_q      <= 1'b0;
      free_phys_q    <= '0;
      retire_valid_q <= 1'b0;
    end else begin
      valid_q        <= valid_d;
      done_q         <= done_d;
      rd_valid_q     <= rd_valid_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      commit_en_q    <= commit_en_d;
      commit_arch_q  <= commit_arch_d;
      commit_phys_q  <= commit_phys_d;
      free_en_q      <= free_en_d;
      free_phys_q    <= free_phys_d;
      retire_valid_q <= retire_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    arch_q <= arch_d;
    phys_q <= phys_d;
    old_q  <= old_d;
  end

  assign commit_en      = commit_en_q;
  assign commit_arch_rd = commit_arch_q;
  assign commit_phys_rd = commit_phys_q;
  assign free_en        = free_en_q;
  assign free_phys      = free_phys_q;
  assign retire_valid   = retire_valid_q;
  assign rob_count      = count_q;

endmodule

// File: tb/tb_commit_unit.sv
// Directed bench for commit_unit (FETCH_W=2, ROB_DEPTH=16, PHYS_REGS=48).
module tb_commit_unit;

  logic            clk;
  logic            reset_n;
  logic [1:0]      disp_valid;
  logic [1:0]      disp_rd_valid;
  logic [1:0][4:0] disp_arch_rd;
  logic [1:0][5:0] disp_phys_rd;
  logic [1:0][5:0] disp_old_phys_rd;
  logic            disp_ready;
  logic [1:0][3:0] disp_rob_idx;
  logic [1:0]      wb_en;
  logic [1:0][3:0] wb_rob_idx;
  logic            flush;
  logic            commit_en;
  logic [4:0]      commit_arch_rd;
  logic [5:0]      commit_phys_rd;
  logic            free_en;
  logic [5:0]      free_phys;
  logic            retire_valid;
  logic [4:0]      rob_count;

  int n_checks = 0;
  int n_errors = 0;

  commit_unit #(
    .FETCH_W  (2),
    .ROB_DEPTH(16),
    .PHYS_REGS(48)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .disp_valid      (disp_valid),
    .disp_rd_valid   (disp_rd_valid),
    .disp_arch_rd    (disp_arch_rd),
    .disp_phys_rd    (disp_phys_rd),
    .disp_old_phys_rd(disp_old_phys_rd),
    .disp_ready      (disp_ready),
    .disp_rob_idx    (disp_rob_idx),
    .wb_en           (wb_en),
    .wb_rob_idx      (wb_rob_idx),
    .flush           (flush),
    .commit_en       (commit_en),
    .commit_arch_rd  (commit_arch_rd),
    .commit_phys_rd  (commit_phys_rd),
    .free_en         (free_en),
    .free_phys       (free_phys),
    .retire_valid    (retire_valid),
    .rob_count       (rob_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    disp_valid       = '0;
    disp_rd_valid    = '0;
    disp_arch_rd     = '0;
    disp_phys_rd     = '0;
    disp_old_phys_rd = '0;
    wb_en            = '0;
    wb_rob_idx       = '0;
    flush            = 1'b0;
  endtask

  task automatic set_lane(input int l, input logic rdv, input logic [4:0] a,
                          input logic [5:0] p, input logic [5:0] o);
    disp_valid[l]       = 1'b1;
    disp_rd_valid[l]    = rdv;
    disp_arch_rd[l]     = a;
    disp_phys_rd[l]     = p;
    disp_old_phys_rd[l] = o;
  endtask

  task automatic wb(input int l, input logic [3:0] idx);
    wb_en[l]      = 1'b1;
    wb_rob_idx[l] = idx;
  endtask

  int exp_arch;
  int n_ret;
  int nk;

  initial begin
    clear_in();
    reset_n = 1'b0;
    #3;
    check("rst_count", 32'(rob_count), 0);
    check("rst_ready", 32'(disp_ready), 1);
    check("rst_idx", 32'(disp_rob_idx), 32'h10);
    check("rst_commit", 32'({commit_en, free_en, retire_valid}), 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Single instruction: dispatch, writeback, retire
    set_lane(0, 1'b1, 5'd5, 6'd33, 6'd5);
    #1;
    check("single_idx0", 32'(disp_rob_idx[0]), 0);
    step();
    clear_in();
    check("single_count1", 32'(rob_count), 1);
    step();
    wb(0, 4'd0);
    step();
    clear_in();
    check("single_no_early", 32'(commit_en), 0);
    step();
    check("single_commit_en", 32'(commit_en), 1);
    check("single_arch", 32'(commit_arch_rd), 5);
    check("single_phys", 32'(commit_phys_rd), 33);
    check("single_free_en", 32'(free_en), 1);
    check("single_free_phys", 32'(free_phys), 5);
    check("single_retire", 32'(retire_valid), 1);
    check("single_count0", 32'(rob_count), 0);
    step();
    check("single_pulse_end", 32'({commit_en, free_en, retire_valid}), 0);

    // Empty flush puts the indices back at 0, then in-order retire
    flush = 1'b1;
    step();
    clear_in();
    set_lane(0, 1'b1, 5'd1, 6'd40, 6'd1);
    set_lane(1, 1'b1, 5'd2, 6'd41, 6'd2);
    #1;
    check("order_idx", 32'(disp_rob_idx), 32'h10);
    step();
    clear_in();
    check("order_count", 32'(rob_count), 2);
    wb(1, 4'd1);
    step();
    clear_in();
    step();
    check("order_wait", 32'({commit_en, retire_valid}), 0);
    wb(0, 4'd0);
    step();
    clear_in();
    check("order_wait2", 32'(retire_valid), 0);
    step();
    check("order_first", 32'(commit_arch_rd), 1);
    check("order_first_phys", 32'(commit_phys_rd), 40);
    check("order_first_free", 32'(free_phys), 1);
    step();
    check("order_second", 32'(commit_arch_rd), 2);
    check("order_second_en", 32'(commit_en), 1);
    check("order_empty", 32'(rob_count), 0);
    step();
    check("order_idle", 32'(retire_valid), 0);

    // Fill from head=tail=2: entry k gets arch k+1, phys 16+k, old k
    for (int g = 0; g < 8; g++) begin
      clear_in();
      set_lane(0, 1'b1, 5'(2 * g + 1), 6'(16 + 2 * g), 6'(2 * g));
      set_lane(1, 1'b1, 5'(2 * g + 2), 6'(17 + 2 * g), 6'(2 * g + 1));
      step();
    end
    clear_in();
    check("full_count", 32'(rob_count), 16);
    check("full_ready", 32'(disp_ready), 0);
    set_lane(0, 1'b1, 5'd30, 6'd1, 6'd2);
    set_lane(1, 1'b1, 5'd31, 6'd3, 6'd4);
    #1;
    check("full_ready_valid", 32'(disp_ready), 0);
    step();
    clear_in();
    check("full_ignored", 32'(rob_count), 16);
    wb(0, 4'd2);
    step();
    clear_in();
    step();
    check("full_ret1_count", 32'(rob_count), 15);
    check("full_ret1_ready", 32'(disp_ready), 0);
    check("full_ret1_arch", 32'(commit_arch_rd), 1);
    wb(0, 4'd3);
    wb(1, 4'd4);
    step();
    clear_in();
    step();
    check("full_ret2_count", 32'(rob_count), 14);
    check("full_ret2_ready", 32'(disp_ready), 1);
    check("full_ret2_arch", 32'(commit_arch_rd), 2);

    // Drain the rest, expecting strict program order
    exp_arch = 3;
    n_ret    = 0;
    nk       = 3;
    for (int i = 0; i < 30; i++) begin
      clear_in();
      if (nk <= 15) wb(0, 4'((2 + nk) % 16));
      nk++;
      if (nk <= 15) wb(1, 4'((2 + nk) % 16));
      nk++;
      step();
      if (retire_valid) begin
        check("drain_arch", 32'(commit_arch_rd), 32'(exp_arch));
        check("drain_phys", 32'(commit_phys_rd), 32'(exp_arch + 15));
        check("drain_free", 32'(free_phys), 32'(exp_arch - 1));
        exp_arch++;
        n_ret++;
      end
    end
    clear_in();
    check("drain_n", 32'(n_ret), 14);
    check("drain_count", 32'(rob_count), 0);

    // Wrapped tail (2) with no-destination and x0 entries
    set_lane(0, 1'b0, 5'd7, 6'd10, 6'd11);
    set_lane(1, 1'b1, 5'd0, 6'd12, 6'd13);
    #1;
    check("wrap_idx", 32'(disp_rob_idx), 32'h32);
    step();
    clear_in();
    set_lane(0, 1'b1, 5'd9, 6'd45, 6'd9);
    #1;
    check("wrap_idx2", 32'(disp_rob_idx), 32'h54);
    step();
    clear_in();
    wb(0, 4'd2);
    wb(1, 4'd3);
    step();
    clear_in();
    wb(0, 4'd4);
    step();
    clear_in();
    check("nodst_retire", 32'(retire_valid), 1);
    check("nodst_en", 32'({commit_en, free_en}), 0);
    step();
    check("x0_retire", 32'(retire_valid), 1);
    check("x0_en", 32'({commit_en, free_en}), 0);
    step();
    check("dst_commit", 32'({commit_en, free_en}), 3);
    check("dst_arch", 32'(commit_arch_rd), 9);
    check("dst_phys", 32'(commit_phys_rd), 45);
    check("dst_free", 32'(free_phys), 9);
    step();
    check("dst_count", 32'(rob_count), 0);

    // Flush with 5 entries (indices 5..9), two done, plus a dispatch and a writeback
    for (int g = 0; g < 3; g++) begin
      clear_in();
      set_lane(0, 1'b1, 5'd10, 6'd20, 6'd21);
      if (g < 2) set_lane(1, 1'b1, 5'd11, 6'd22, 6'd23);
      step();
    end
    clear_in();
    wb(0, 4'd7);
    wb(1, 4'd8);
    step();
    clear_in();
    check("flush_pre_count", 32'(rob_count), 5);
    flush = 1'b1;
    set_lane(0, 1'b1, 5'd12, 6'd24, 6'd25);
    set_lane(1, 1'b1, 5'd13, 6'd26, 6'd27);
    wb(0, 4'd5);
    step();
    clear_in();
    check("flush_count", 32'(rob_count), 0);
    check("flush_pulses", 32'({commit_en, free_en, retire_valid}), 0);
    set_lane(0, 1'b1, 5'd3, 6'd20, 6'd3);
    set_lane(1, 1'b1, 5'd4, 6'd21, 6'd4);
    #1;
    check("flush_idx", 32'(disp_rob_idx), 32'h10);
    check("flush_ready", 32'(disp_ready), 1);
    step();
    clear_in();
    check("flush_redisp", 32'(rob_count), 2);
    step();
    check("flush_no_ret", 32'(retire_valid), 0);

    // Reset pulse while a commit pulse is on the outputs
    wb(0, 4'd0);
    step();
    clear_in();
    step();
    check("rstmid_commit", 32'(commit_en), 1);
    check("rstmid_arch", 32'(commit_arch_rd), 3);
    #1;
    reset_n = 1'b0;
    #1;
    check("rstmid_pulses", 32'({commit_en, free_en, retire_valid}), 0);
    check("rstmid_count", 32'(rob_count), 0);
    check("rstmid_ready", 32'(disp_ready), 1);
    check("rstmid_idx", 32'(disp_rob_idx), 32'h10);
    step();
    reset_n = 1'b1;
    check("rstmid_hold", 32'({commit_en, retire_valid}), 0);
    set_lane(0, 1'b1, 5'd6, 6'd30, 6'd6);
    #1;
    check("rstmid_idx_after", 32'(disp_rob_idx), 32'h10);
    step();
    clear_in();
    check("rstmid_count_after", 32'(rob_count), 1);
    step();
    check("rstmid_quiet", 32'(retire_valid), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
